// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO: LSB-first frames, optional parity, 1-2 stop bits.
// A word accepted into an idle, empty queue starts its start bit one cycle later; queued frames follow with no gap.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sourceClk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic                          tx_complete,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = $clog2(CLK_DIV);
    localparam logic [AW:0]     FULL      = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic            ODD       = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop, empty;
    logic [CW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] sr;
    logic                 par;
    logic                 bit_end, last_data, last_stop;
    logic                 tx_out_nxt, tx_busy_nxt, tx_complete_nxt;

    assign tx_ready  = (fifo_count != FULL);
    assign empty     = (fifo_count == '0);
    assign push      = tx_valid & tx_ready;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign last_data = (bit_cnt == BIT_LAST);
    assign last_stop = (bit_cnt == STOP_LAST);

    always_ff @(posedge sourceClk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge sourceClk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge sourceClk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_START;
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA:  if (bit_end && last_data) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (bit_end) state_nxt = S_STOP;
            S_STOP:  if (bit_end && last_stop) state_nxt = empty ? S_IDLE : S_START;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered so the line never glitches.
    always_comb begin
        pop             = 1'b0;
        tx_out_nxt      = tx_out;
        tx_busy_nxt     = tx_busy;
        tx_complete_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                tx_out_nxt = 1'b1;
                if (!empty) begin
                    pop         = 1'b1;
                    tx_out_nxt  = 1'b0;
                    tx_busy_nxt = 1'b1;
                end
            end
            S_START: if (bit_end) tx_out_nxt = sr[0];
            S_DATA:  if (bit_end) tx_out_nxt = last_data ? ((PARITY != 0) ? par : 1'b1) : sr[1];
            S_PAR:   if (bit_end) tx_out_nxt = 1'b1;
            S_STOP: begin
                if (bit_end && last_stop) begin
                    tx_complete_nxt = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        tx_out_nxt = 1'b0;
                    end else begin
                        tx_busy_nxt = 1'b0;
                    end
                end
            end
            default: tx_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sourceClk or posedge reset) begin
        if (reset) begin
            tx_out      <= 1'b1;
            tx_busy     <= 1'b0;
            tx_complete <= 1'b0;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            sr          <= '0;
            par         <= 1'b0;
        end else begin
            tx_out      <= tx_out_nxt;
            tx_busy     <= tx_busy_nxt;
            tx_complete <= tx_complete_nxt;
            if (pop || state == S_IDLE || bit_end) baud_cnt <= '0;
            else                                   baud_cnt <= baud_cnt + 1'b1;
            // bit_cnt indexes data bits in DATA and stop bits in STOP
            if (pop)
                bit_cnt <= '0;
            else if (bit_end)
                bit_cnt <= ((state == S_DATA && !last_data) || (state == S_STOP && !last_stop))
                           ? bit_cnt + 1'b1 : '0;
            if (pop) begin
                sr  <= mem[rd_ptr];
                par <= (^mem[rd_ptr]) ^ ODD;
            end else if (state == S_DATA && bit_end) begin
                sr <= sr >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, 7O2, 7E2 and 5N1 framing at CLK_DIV=4.
module tb_uart_tx_fifo;
    localparam int CD = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       vld = '0;
    logic [7:0]       din = '0;
    logic [1:0]       sel = '0;
    logic [3:0]       rdy, out, busy, cmp;
    logic [3:0][2:0]  cnt;
    logic             o_out, o_busy, o_cmp, o_rdy;
    logic [2:0]       o_cnt;
    int               n_cmp = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .sourceClk(clk), .reset(rst), .tx_valid(vld[0]), .tx_data(din), .tx_ready(rdy[0]),
        .tx_out(out[0]), .tx_busy(busy[0]), .tx_complete(cmp[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .sourceClk(clk), .reset(rst), .tx_valid(vld[1]), .tx_data(din[6:0]), .tx_ready(rdy[1]),
        .tx_out(out[1]), .tx_busy(busy[1]), .tx_complete(cmp[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
        .sourceClk(clk), .reset(rst), .tx_valid(vld[2]), .tx_data(din[6:0]), .tx_ready(rdy[2]),
        .tx_out(out[2]), .tx_busy(busy[2]), .tx_complete(cmp[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_d (
        .sourceClk(clk), .reset(rst), .tx_valid(vld[3]), .tx_data(din[4:0]), .tx_ready(rdy[3]),
        .tx_out(out[3]), .tx_busy(busy[3]), .tx_complete(cmp[3]), .fifo_count(cnt[3]));

    always_comb begin
        o_out  = out[sel];
        o_busy = busy[sel];
        o_cmp  = cmp[sel];
        o_rdy  = rdy[sel];
        o_cnt  = cnt[sel];
    end

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        din      = d;
        vld[sel] = 1'b1;
        @(posedge clk);
        #1;
        vld[sel] = 1'b0;
    endtask

    // Called just after the accepting edge; bits[0] is the start bit.
    task automatic check_frame(input string nm, input logic [15:0] bits, input int nb);
        logic b;
        @(posedge clk);
        for (int k = 0; k < nb * CD; k++) begin
            @(negedge clk);
            b = bits[4'(k / CD)];
            n_cmp++;
            if (o_out !== b || o_busy !== 1'b1 || o_cmp !== 1'b0) begin
                n_err++;
                $display("FAIL %s cycle %0d: out/busy/done=%b%b%b required %b10", nm, k, o_out, o_busy, o_cmp, b);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({o_out, o_busy, o_cmp} !== 3'b101) begin
            n_err++;
            $display("FAIL %s end: out/busy/done=%b%b%b required 101", nm, o_out, o_busy, o_cmp);
        end
        @(negedge clk);
        n_cmp++;
        if (o_cmp !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse width: done=%b required 0", nm, o_cmp);
        end
    endtask

    task automatic test_reset();
        sel = 2'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({o_out, o_busy, o_cmp, o_rdy} !== 4'b1001 || o_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL reset: out/busy/done/ready=%b%b%b%b count=%0d required 1001 count=0",
                     o_out, o_busy, o_cmp, o_rdy, o_cnt);
        end
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single();
        sel = 2'd0;
        push(8'hA5);
        @(negedge clk);
        n_cmp++;
        if (o_cnt !== 3'd1 || o_out !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL accept_latency: count=%0d out=%b busy=%b required 1 1 0", o_cnt, o_out, o_busy);
        end
        check_frame("8n1_a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        n_cmp++;
        if (o_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL 8n1_count_after: count=%0d required 0", o_cnt);
        end
    endtask

    task automatic test_parity();
        sel = 2'd1;
        push(8'h55);
        check_frame("7o2_55", {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 11);
        sel = 2'd2;
        push(8'h55);
        check_frame("7e2_55", {5'b0, 2'b11, 1'b0, 7'h55, 1'b0}, 11);
    endtask

    task automatic test_word5();
        sel = 2'd3;
        push(8'h1F);
        check_frame("5n1_1f", {9'b0, 1'b1, 5'h1F, 1'b0}, 7);
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [6] = '{8'h3C, 8'h81, 8'h5A, 8'hF0, 8'h0E, 8'hC3};
        logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] exp_cnt [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [9:0] fb;
        logic       r, e, ec;
        int         idx = 0, guard = 0, waited = 0, pulses = 0, f, b;
        sel = 2'd0;
        fork
            begin
                while (idx < 6 && guard < 400) begin
                    @(negedge clk);
                    din    = words[idx];
                    vld[0] = 1'b1;
                    r      = o_rdy;
                    if (guard < 6) begin
                        n_cmp++;
                        if (r !== exp_rdy[guard] || o_cnt !== exp_cnt[guard]) begin
                            n_err++;
                            $display("FAIL b2b_fill %0d: ready=%b count=%0d required %b %0d",
                                     guard, r, o_cnt, exp_rdy[guard], exp_cnt[guard]);
                        end
                    end
                    guard++;
                    @(posedge clk);
                    if (r) idx++;
                end
                #1 vld[0] = 1'b0;
                n_cmp++;
                if (idx != 6) begin
                    n_err++;
                    $display("FAIL b2b_push_timeout: pushed=%0d required 6", idx);
                end
            end
            begin
                do begin
                    @(negedge clk);
                    waited++;
                end while (o_busy !== 1'b1 && waited < 20);
                for (int k = 0; k < 6 * 10 * CD; k++) begin
                    if (k > 0) @(negedge clk);
                    f  = k / (10 * CD);
                    b  = (k % (10 * CD)) / CD;
                    fb = {1'b1, words[f], 1'b0};
                    e  = fb[4'(b)];
                    ec = (k % (10 * CD) == 0) && (k != 0);
                    if (o_cmp === 1'b1) pulses++;
                    n_cmp++;
                    if (o_out !== e || o_busy !== 1'b1 || o_cmp !== ec) begin
                        n_err++;
                        $display("FAIL b2b cycle %0d: out/busy/done=%b%b%b required %b1%b",
                                 k, o_out, o_busy, o_cmp, e, ec);
                    end
                end
                @(negedge clk);
                if (o_cmp === 1'b1) pulses++;
                n_cmp++;
                if ({o_out, o_busy, o_cmp} !== 3'b101 || pulses != 6) begin
                    n_err++;
                    $display("FAIL b2b_end: out/busy/done=%b%b%b pulses=%0d required 101 pulses=6",
                             o_out, o_busy, o_cmp, pulses);
                end
            end
        join
    endtask

    task automatic test_push_pop_boundary();
        int waited = 0;
        sel = 2'd0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (38) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_cnt !== 3'd2 || o_busy !== 1'b1 || o_out !== 1'b1 || o_cmp !== 1'b0) begin
            n_err++;
            $display("FAIL boundary_before: count=%0d busy=%b out=%b done=%b required 2 1 1 0",
                     o_cnt, o_busy, o_out, o_cmp);
        end
        din    = 8'h44;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_cnt !== 3'd2 || o_cmp !== 1'b1 || o_out !== 1'b0 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL boundary_after: count=%0d done=%b out=%b busy=%b required 2 1 0 1",
                     o_cnt, o_cmp, o_out, o_busy);
        end
        while ((o_busy !== 1'b0 || o_cnt !== 3'd0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (o_busy !== 1'b0 || o_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL boundary_drain: busy=%b count=%0d required 0 0", o_busy, o_cnt);
        end
    endtask

    task automatic test_reset_mid();
        sel = 2'd0;
        push(8'h0F);
        push(8'hAA);
        push(8'hBB);
        // Lands inside data bit 4 of 0x0F, which is low.
        repeat (20) @(posedge clk);
        #2;
        n_cmp++;
        if (o_out !== 1'b0 || o_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL pre_reset: out=%b count=%0d required 0 2", o_out, o_cnt);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_out, o_busy, o_cmp, o_rdy} !== 4'b1001 || o_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset: out/busy/done/ready=%b%b%b%b count=%0d required 1001 count=0",
                     o_out, o_busy, o_cmp, o_rdy, o_cnt);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n_cmp++;
            if (o_out !== 1'b1 || o_busy !== 1'b0 || o_cnt !== 3'd0) begin
                n_err++;
                $display("FAIL post_reset_idle cycle %0d: out=%b busy=%b count=%0d required 1 0 0",
                         k, o_out, o_busy, o_cnt);
            end
        end
        push(8'h96);
        check_frame("after_reset_96", {6'b0, 1'b1, 8'h96, 1'b0}, 10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_word5();
        test_back_to_back();
        test_push_pop_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
